// File: rtl/beep_sequencer_pkg.sv
// Shared types and sizing helpers for beep_sequencer and its cycle timer.
package beep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        OFF  = 2'b10
    } state_e;

    // Bits needed to hold max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val + 1);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/beep_sequencer_if.sv
// Trigger/cancel request and pattern/status outputs of beep_sequencer.
interface beep_sequencer_if;
    logic trig;
    logic cancel;
    logic z;
    logic busy;
    logic done;

    modport master (output trig, cancel, input z, busy, done);
    modport slave  (input trig, cancel, output z, busy, done);
endinterface

// File: rtl/beep_sequencer_cycle_timer.sv
// Loadable down-counter; expired marks the final cycle of a loaded interval.
module cycle_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Stops at zero so an idle timer never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/beep_sequencer.sv
// Turns a trigger pulse into BEEPS bursts of ON_CYCLES high separated by OFF_CYCLES low.
// Optional: define BEEP_SEQUENCER_RETRIGGER_EN to let trig restart a running sequence.
module beep_sequencer
    import beep_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 4,
    parameter int unsigned OFF_CYCLES = 4,
    parameter int unsigned BEEPS      = 3
) (
    input  logic             clk,
    input  logic             rst,
    beep_sequencer_if.slave  bus
);

    localparam int unsigned CW = cnt_width(max2(ON_CYCLES, OFF_CYCLES));
    localparam int unsigned BW = cnt_width(BEEPS);
    localparam logic [CW-1:0] ON_LD  = CW'(ON_CYCLES);
    localparam logic [CW-1:0] OFF_LD = CW'(OFF_CYCLES);
    localparam logic [BW-1:0] BEEP_LD = BW'(BEEPS);

    state_e          state_q, state_d;
    logic [BW-1:0]   beep_q, beep_d;
    logic            z_q, z_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            tmr_load;
    logic [CW-1:0]   tmr_val;
    logic            tmr_en;
    logic            tmr_exp;
    logic            start;
    logic            retrig;

    assign start = bus.trig && !bus.cancel;
`ifdef BEEP_SEQUENCER_RETRIGGER_EN
    assign retrig = start;
`else
    assign retrig = 1'b0;
`endif

    cycle_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d  = state_q;
        beep_d   = beep_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = ON;
                    beep_d   = BEEP_LD;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LD;
                end
            end
            ON, OFF: begin
                tmr_en = 1'b1;
                if (bus.cancel) begin
                    state_d  = IDLE;
                    beep_d   = '0;
                    tmr_load = 1'b1;
                end else if (retrig) begin
                    state_d  = ON;
                    beep_d   = BEEP_LD;
                    tmr_load = 1'b1;
                    tmr_val  = ON_LD;
                end else if (tmr_exp) begin
                    tmr_load = 1'b1;
                    if (state_q == OFF) begin
                        state_d = ON;
                        tmr_val = ON_LD;
                    end else if (beep_q <= BW'(1)) begin
                        // Last burst: no trailing gap, go straight to IDLE.
                        state_d = IDLE;
                        beep_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = OFF;
                        beep_d  = beep_q - 1'b1;
                        tmr_val = OFF_LD;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                beep_d   = '0;
                tmr_load = 1'b1;
            end
        endcase
        z_d    = (state_d == ON);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beep_q  <= '0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beep_q  <= beep_d;
            z_q     <= z_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.z    = z_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_beep_sequencer.sv
// Bench for beep_sequencer: two configurations driven in lockstep against a schedule-position model.
module tb_beep_sequencer;

`ifdef BEEP_SEQUENCER_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    localparam int unsigned A_ON = 3, A_OFF = 2, A_BEEPS = 2;
    localparam int unsigned B_ON = 1, B_OFF = 1, B_BEEPS = 1;

    typedef struct packed {
        logic        active;
        logic [15:0] pos;
        logic        done;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    mdl_t ma, mb;

    beep_sequencer_if ifa ();
    beep_sequencer_if ifb ();

    beep_sequencer #(.ON_CYCLES(A_ON), .OFF_CYCLES(A_OFF), .BEEPS(A_BEEPS)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    beep_sequencer #(.ON_CYCLES(B_ON), .OFF_CYCLES(B_OFF), .BEEPS(B_BEEPS)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sequence viewed as a position in a BEEPS*ON + (BEEPS-1)*OFF cycle schedule.
    function automatic mdl_t mdl_next(input mdl_t m, input int unsigned on, input int unsigned off,
                                      input int unsigned beeps, input bit r, input bit t, input bit c);
        mdl_t n;
        int unsigned total;
        total  = beeps * on + (beeps - 1) * off;
        n      = m;
        n.done = 1'b0;
        if (r || c) begin
            n.active = 1'b0;
        end else if (t && (!m.active || RETRIG)) begin
            n.active = 1'b1;
            n.pos    = '0;
        end else if (m.active) begin
            if (int'(m.pos) + 1 == int'(total)) begin
                n.active = 1'b0;
                n.done   = 1'b1;
            end else begin
                n.pos = m.pos + 1'b1;
            end
        end
        return n;
    endfunction

    function automatic bit mdl_z(input mdl_t m, input int unsigned on, input int unsigned off);
        return m.active && ((int'(m.pos) % int'(on + off)) < int'(on));
    endfunction

    task automatic step_cycle(input bit r, input bit t, input bit c);
        rst        = r;
        ifa.trig   = t;
        ifa.cancel = c;
        ifb.trig   = t;
        ifb.cancel = c;
        @(posedge clk);
        ma = mdl_next(ma, A_ON, A_OFF, A_BEEPS, r, t, c);
        mb = mdl_next(mb, B_ON, B_OFF, B_BEEPS, r, t, c);
        #1;
        check_eq("a_z",    32'(ifa.z),    32'(mdl_z(ma, A_ON, A_OFF)));
        check_eq("a_busy", 32'(ifa.busy), 32'(ma.active));
        check_eq("a_done", 32'(ifa.done), 32'(ma.done));
        check_eq("b_z",    32'(ifb.z),    32'(mdl_z(mb, B_ON, B_OFF)));
        check_eq("b_busy", 32'(ifb.busy), 32'(mb.active));
        check_eq("b_done", 32'(ifb.done), 32'(mb.done));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ma = '0;
        mb = '0;
        // Reset, then quiet inputs.
        step_cycle(1'b1, 1'b0, 1'b0);
        step_cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(10);
        // Full sequence.
        step_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(11);
        // Cancel during the gap.
        step_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(4);
        step_cycle(1'b0, 1'b0, 1'b1);
        idle_cycles(10);
        // Second trig while busy.
        step_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(3);
        step_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(12);
        // trig with cancel in IDLE, then reset mid-sequence.
        step_cycle(1'b0, 1'b1, 1'b1);
        idle_cycles(3);
        step_cycle(1'b0, 1'b1, 1'b0);
        idle_cycles(1);
        step_cycle(1'b1, 1'b0, 1'b0);
        idle_cycles(10);
        // Cancel held as a level across a trig.
        step_cycle(1'b0, 1'b1, 1'b0);
        step_cycle(1'b0, 1'b0, 1'b1);
        step_cycle(1'b0, 1'b1, 1'b1);
        idle_cycles(4);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step_cycle($urandom_range(0, 99) == 0,
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 29) == 0);
        end
        idle_cycles(20);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
